dual_issue_queue: RTL
=====================

DUAL_ISSUE_QUEUE -- requirements
Module: dual_issue_queue

Interface
REQ-001 clock  in  1  single rising-edge clock for all state.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 flush  in  1  synchronous squash of queue and DX outputs (branch/jump redirect).
REQ-004 in_valid_1, in_valid_2  in  1 each  decoded instruction present on fetch slot 1 / slot 2.
REQ-005 in_rs_k, in_rt_k, in_rd_k  in  5 each (k=1,2)  source/destination register fields.
REQ-006 in_regWrite_k, in_memToReg_k, in_ctrl_k  in  1 each  writes rd / is load / is branch-jump-bex-jr.
REQ-007 in_tag_k  in  8  opaque instruction tag (PC low bits).
REQ-008 in_ready  out  1  queue accepts a pair this cycle.
REQ-009 DX_valid_k  out  1  DX latch of pipe k holds a real instruction.
REQ-010 DX_rs_k, DX_rt_k, DX_rd_k  out  5; DX_regWrite_k, DX_memToReg_k, DX_ctrl_k  out  1; DX_tag_k  out  8  registered DX latch fields feeding the bypass unit.
REQ-011 stall_cnt  out  16  count of cycles in which the head was valid but did not issue.

Function
REQ-012 Storage: 4-entry circular FIFO of 26-bit entries {rs,rt,rd,regWrite,memToReg,ctrl,tag}, 2-bit head/tail pointers wrapping 3->0, 3-bit occupancy count 0..4.
REQ-013 in_ready = (count <= 2), combinational from current count only.
REQ-014 Enqueue at edge when in_ready & in_valid_1 & !flush: slot 1 to tail, then slot 2 to tail+1 if in_valid_2; in_valid_2 without in_valid_1 is ignored.
REQ-015 Enqueued entry is eligible for issue the cycle after the write edge (no queue bypass).
REQ-016 Load-use hazard for entry E: some DX_valid_k & DX_memToReg_k & DX_rd_k != 0 & DX_rd_k in {E.rs, E.rt}.
REQ-017 Slot-1 issue: head valid (count>=1) and head has no load-use hazard.
REQ-018 Slot-2 issue: slot 1 issues, count>=2, head.ctrl=0, entry head+1 has no load-use hazard, and no intra-pair dependency.
REQ-019 Intra-pair dependency: head.regWrite & head.rd != 0 & head.rd in {second.rs, second.rt, second.rd}.
REQ-020 Control instructions issue only in pipe 1; a ctrl entry at head+1 waits to become head.
REQ-021 Issue is in order; pipe 2 never issues without pipe 1.
REQ-022 At each edge, DX latch k loads the issued entry with DX_valid_k=1; when slot k does not issue, all DX_k fields load 0 (bubble, rd=0).
REQ-023 count_next = count + enq_num - iss_num; simultaneous enqueue and issue are both honoured; occupancy never exceeds 4 and never underflows.
REQ-024 stall_cnt increments when count>=1 and slot 1 does not issue and flush=0; saturates at 16'hFFFF.
REQ-025 flush=1: at the edge, count, head and tail go to 0, all DX fields go to 0, and that cycle's enqueue and issue are discarded; stall_cnt is held.
REQ-026 Latency: instruction presented at edge N reaches DX outputs at edge N+1 at the earliest.

Reset
REQ-027 On reset low, asynchronously: count, head and tail are 0; all DX outputs are 0; stall_cnt is 0; in_ready is 1.
REQ-028 Reset asserted mid-operation discards all queued entries; FIFO data storage need not be cleared.
REQ-029 First enqueue is accepted at the first rising edge after reset deasserts.

Verification
REQ-030 Independent pair: enqueue (rd=1,rs=2,rt=3) + (rd=4,rs=5,rt=6) -> next edge DX_valid_1=DX_valid_2=1, DX_rd_1=1, DX_rd_2=4.
REQ-031 RAW pair: slot 1 rd=5 regWrite=1, slot 2 rs=5 -> pipe 1 issues, DX_valid_2=0; next cycle second instruction issues in DX_1.
REQ-032 Load-use: DX_1 holds load rd=7, head rs=7 -> all DX_valid=0 for one cycle and stall_cnt+1; issues the following cycle.
REQ-033 Fill: 3 stalled cycles with paired enqueue -> count=4, in_ready=0, extra input ignored; pointers wrap correctly on drain.
REQ-034 Ctrl: head ctrl=1 with a valid head+1 -> only pipe 1 issues; flush with count=3 -> next cycle count=0 and DX_valid=0 regardless of in_valid.
REQ-035 Reset asserted with count=2 and DX valid -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dual_issue_queue.sv
// ---------------------------------------------------------------------------
// dual_issue_queue
//
// Purpose:
//   A 4-entry in-order instruction queue that sits between decode and the
//   DX pipeline latches of a two-wide pipeline. Decode offers up to two
//   instructions per cycle. The queue issues up to two instructions per cycle
//   into the DX latches of pipe 1 and pipe 2, subject to these rules:
//     - a load-use hazard against a load already in DX holds the instruction;
//     - a dependency inside the issuing pair keeps the second instruction back;
//     - control instructions (branch/jump/bex/jr) issue only in pipe 1.
//   A flush squashes the queue contents and both DX latches.
//
// Ports:
//   clock                    rising-edge clock for all state
//   reset                    asynchronous, active-low reset
//   flush                    synchronous squash of the queue and the DX latches
//   in_valid_k               fetch slot k (k=1,2) holds a decoded instruction
//   in_rs_k/in_rt_k/in_rd_k  source and destination register fields
//   in_regWrite_k            instruction writes rd
//   in_memToReg_k            instruction is a load
//   in_ctrl_k                instruction is a branch/jump/bex/jr
//   in_tag_k                 opaque instruction tag (low PC bits)
//   in_ready                 queue accepts a pair this cycle
//   DX_*_k                   registered DX latch of pipe k (feeds the bypass unit)
//   stall_cnt                saturating count of cycles in which the head
//                            was valid but did not issue
// ---------------------------------------------------------------------------
module dual_issue_queue (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid_1,
  input  logic [4:0]  in_rs_1,
  input  logic [4:0]  in_rt_1,
  input  logic [4:0]  in_rd_1,
  input  logic        in_regWrite_1,
  input  logic        in_memToReg_1,
  input  logic        in_ctrl_1,
  input  logic [7:0]  in_tag_1,
  input  logic        in_valid_2,
  input  logic [4:0]  in_rs_2,
  input  logic [4:0]  in_rt_2,
  input  logic [4:0]  in_rd_2,
  input  logic        in_regWrite_2,
  input  logic        in_memToReg_2,
  input  logic        in_ctrl_2,
  input  logic [7:0]  in_tag_2,
  output logic        in_ready,
  output logic        DX_valid_1,
  output logic [4:0]  DX_rs_1,
  output logic [4:0]  DX_rt_1,
  output logic [4:0]  DX_rd_1,
  output logic        DX_regWrite_1,
  output logic        DX_memToReg_1,
  output logic        DX_ctrl_1,
  output logic [7:0]  DX_tag_1,
  output logic        DX_valid_2,
  output logic [4:0]  DX_rs_2,
  output logic [4:0]  DX_rt_2,
  output logic [4:0]  DX_rd_2,
  output logic        DX_regWrite_2,
  output logic        DX_memToReg_2,
  output logic        DX_ctrl_2,
  output logic [7:0]  DX_tag_2,
  output logic [15:0] stall_cnt
);

  // One queue entry / one DX latch payload (26 bits).
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_to_reg;
    logic       ctrl;
    logic [7:0] tag;
  } entry_t;

  entry_t     mem [4];
  logic [1:0] head;
  logic [1:0] tail;
  logic [2:0] count;

  entry_t     dx_1;
  entry_t     dx_2;
  logic       dx_valid_1;
  logic       dx_valid_2;

  entry_t     in_e1;
  entry_t     in_e2;
  entry_t     head_e;
  entry_t     next_e;
  logic [1:0] head_p1;
  logic [1:0] tail_p1;

  logic       enq_1;
  logic       enq_2;
  logic       iss_1;
  logic       iss_2;
  logic [2:0] enq_num;
  logic [2:0] iss_num;
  logic [4:0] load_rd_1;
  logic [4:0] load_rd_2;
  logic       head_hazard;
  logic       next_hazard;
  logic       pair_dep;

  // True when rs or rt reads a register that a load currently in DX will
  // write. A load_rd of 0 means "no load in that pipe" (r0 is never a hazard).
  function automatic logic load_use(input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] l1, input logic [4:0] l2);
    logic hit;
    hit = 1'b0;
    if (l1 != 5'd0 && (l1 == rs || l1 == rt)) hit = 1'b1;
    if (l2 != 5'd0 && (l2 == rs || l2 == rt)) hit = 1'b1;
    return hit;
  endfunction

  assign in_e1   = '{rs: in_rs_1, rt: in_rt_1, rd: in_rd_1, reg_write: in_regWrite_1,
                     mem_to_reg: in_memToReg_1, ctrl: in_ctrl_1, tag: in_tag_1};
  assign in_e2   = '{rs: in_rs_2, rt: in_rt_2, rd: in_rd_2, reg_write: in_regWrite_2,
                     mem_to_reg: in_memToReg_2, ctrl: in_ctrl_2, tag: in_tag_2};

  assign head_p1 = head + 2'd1;
  assign tail_p1 = tail + 2'd1;
  assign head_e  = mem[head];
  assign next_e  = mem[head_p1];

  // Room for a full pair is required before anything is accepted.
  assign in_ready = (count <= 3'd2);

  // Slot 2 is only ever written together with slot 1.
  assign enq_1 = in_ready & in_valid_1 & ~flush;
  assign enq_2 = enq_1 & in_valid_2;

  // Destination of any load sitting in the DX latches, 0 when none.
  assign load_rd_1 = (dx_valid_1 & dx_1.mem_to_reg) ? dx_1.rd : 5'd0;
  assign load_rd_2 = (dx_valid_2 & dx_2.mem_to_reg) ? dx_2.rd : 5'd0;

  assign head_hazard = load_use(head_e.rs, head_e.rt, load_rd_1, load_rd_2);
  assign next_hazard = load_use(next_e.rs, next_e.rt, load_rd_1, load_rd_2);

  // The second instruction of a pair may not read or overwrite the head's rd.
  assign pair_dep = head_e.reg_write && (head_e.rd != 5'd0) &&
                    ((head_e.rd == next_e.rs) || (head_e.rd == next_e.rt) ||
                     (head_e.rd == next_e.rd));

  // Occupancy is tested first so stale storage never influences issue.
  assign iss_1 = (count != 3'd0) && !head_hazard;
  assign iss_2 = iss_1 && (count >= 3'd2) && !head_e.ctrl && !next_hazard && !pair_dep;

  assign enq_num = {2'b00, enq_1} + {2'b00, enq_2};
  assign iss_num = {2'b00, iss_1} + {2'b00, iss_2};

  // Queue storage carries no reset; occupancy alone decides what is live.
  // Enqueue only happens with count <= 2, so the written slots never alias
  // the entries being read for issue in the same cycle.
  always_ff @(posedge clock) begin
    if (enq_1) mem[tail] <= in_e1;
    if (enq_2) mem[tail_p1] <= in_e2;
  end

  // Pointers, occupancy, DX latches and the stall counter. Flush clears the
  // queue and DX but deliberately leaves stall_cnt untouched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head       <= 2'd0;
      tail       <= 2'd0;
      count      <= 3'd0;
      dx_1       <= '0;
      dx_2       <= '0;
      dx_valid_1 <= 1'b0;
      dx_valid_2 <= 1'b0;
      stall_cnt  <= 16'd0;
    end else if (flush) begin
      head       <= 2'd0;
      tail       <= 2'd0;
      count      <= 3'd0;
      dx_1       <= '0;
      dx_2       <= '0;
      dx_valid_1 <= 1'b0;
      dx_valid_2 <= 1'b0;
    end else begin
      head       <= head + iss_num[1:0];
      tail       <= tail + enq_num[1:0];
      count      <= count + enq_num - iss_num;
      dx_1       <= iss_1 ? head_e : '0;
      dx_2       <= iss_2 ? next_e : '0;
      dx_valid_1 <= iss_1;
      dx_valid_2 <= iss_2;
      if ((count != 3'd0) && !iss_1 && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign DX_valid_1    = dx_valid_1;
  assign DX_rs_1       = dx_1.rs;
  assign DX_rt_1       = dx_1.rt;
  assign DX_rd_1       = dx_1.rd;
  assign DX_regWrite_1 = dx_1.reg_write;
  assign DX_memToReg_1 = dx_1.mem_to_reg;
  assign DX_ctrl_1     = dx_1.ctrl;
  assign DX_tag_1      = dx_1.tag;

  assign DX_valid_2    = dx_valid_2;
  assign DX_rs_2       = dx_2.rs;
  assign DX_rt_2       = dx_2.rt;
  assign DX_rd_2       = dx_2.rd;
  assign DX_regWrite_2 = dx_2.reg_write;
  assign DX_memToReg_2 = dx_2.mem_to_reg;
  assign DX_ctrl_2     = dx_2.ctrl;
  assign DX_tag_2      = dx_2.tag;

endmodule
